// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared encodings for the LEGv8 multi-cycle control FSM
package legv8_pkg;

  localparam int CW_W = 30;

  localparam logic [4:0] FS_ADD_C = 5'b01000;
  localparam logic [4:0] FS_SUB_C = 5'b01001;
  localparam logic [4:0] FS_AND_C = 5'b00000;
  localparam logic [4:0] FS_ORR_C = 5'b00100;
  localparam logic [4:0] FS_EOR_C = 5'b01100;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_REG    = 2'b10;
  localparam logic [1:0] PS_BRANCH = 2'b11;

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_ADDS = 11'h558;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_SUBS = 11'h758;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_EOR  = 11'h650;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_BR   = 11'h6B0;
  localparam logic [9:0]  OPC_ADDI = 10'h244;
  localparam logic [9:0]  OPC_SUBI = 10'h344;
  localparam logic [9:0]  OPC_ANDI = 10'h248;
  localparam logic [9:0]  OPC_ORRI = 10'h2C8;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [7:0]  OPC_CBNZ = 8'hB5;
  localparam logic [7:0]  OPC_BCND = 8'h54;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEM     = 2'd2,
    ST_BRANCH  = 2'd3
  } state_e;

  typedef enum logic [4:0] {
    OP_ILLEGAL, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_LDUR, OP_STUR,
    OP_B, OP_BL, OP_BR, OP_CBZ, OP_CBNZ, OP_BCOND
  } op_e;

  typedef struct packed {
    logic       en_pc;
    logic       en_mem;
    logic       en_alu;
    logic       pc_sel;
    logic       b_sel;
    logic       sl;
    logic       wm;
    logic       wr;
    logic [1:0] ps;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } ctrl_word_t;

  // Opcode fields overlap by format width, so the shortest opcodes are matched first.
  function automatic op_e decode_op(input logic [10:0] opc);
    op_e op;
    op = OP_ILLEGAL;
    if      (opc[10:5] == OPC_B)    op = OP_B;
    else if (opc[10:5] == OPC_BL)   op = OP_BL;
    else if (opc[10:3] == OPC_BCND) op = OP_BCOND;
    else if (opc[10:3] == OPC_CBZ)  op = OP_CBZ;
    else if (opc[10:3] == OPC_CBNZ) op = OP_CBNZ;
    else if (opc[10:1] == OPC_ADDI) op = OP_ADDI;
    else if (opc[10:1] == OPC_SUBI) op = OP_SUBI;
    else if (opc[10:1] == OPC_ANDI) op = OP_ANDI;
    else if (opc[10:1] == OPC_ORRI) op = OP_ORRI;
    else begin
      case (opc)
        OPC_ADD:  op = OP_ADD;
        OPC_ADDS: op = OP_ADDS;
        OPC_SUB:  op = OP_SUB;
        OPC_SUBS: op = OP_SUBS;
        OPC_AND:  op = OP_AND;
        OPC_ORR:  op = OP_ORR;
        OPC_EOR:  op = OP_EOR;
        OPC_LDUR: op = OP_LDUR;
        OPC_STUR: op = OP_STUR;
        OPC_BR:   op = OP_BR;
        default:  op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

  // flags = {V, C, N, Z}
  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
    logic t;
    case (cond)
      4'h0:    t = flags[0];
      4'h1:    t = !flags[0];
      4'h2:    t = flags[2];
      4'h3:    t = !flags[2];
      4'h4:    t = flags[1];
      4'h5:    t = !flags[1];
      4'hA:    t = (flags[1] == flags[3]);
      4'hB:    t = (flags[1] != flags[3]);
      4'hE:    t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_extend_legv8.sv
// rtl/imm_extend_legv8.sv - immediate extraction and extension by instruction format
module imm_extend_legv8
  import legv8_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [63:0] constant_o
);

  op_e op;
  assign op = decode_op(ir_i[31:21]);

  always_comb begin
    constant_o = '0;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: constant_o = {52'd0, ir_i[21:10]};
      OP_LDUR, OP_STUR:                   constant_o = {{55{ir_i[20]}}, ir_i[20:12]};
      OP_B, OP_BL:                        constant_o = {{38{ir_i[25]}}, ir_i[25:0]};
      OP_CBZ, OP_CBNZ, OP_BCOND:          constant_o = {{45{ir_i[23]}}, ir_i[23:5]};
      default:                            constant_o = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm_legv8.sv
// rtl/control_fsm_legv8.sv - multi-cycle LEGv8 control unit (fetch/execute/mem/branch)
module control_fsm_legv8
  import legv8_pkg::*;
#(
  parameter logic [4:0] FS_ADD = FS_ADD_C,
  parameter logic [4:0] FS_SUB = FS_SUB_C,
  parameter logic [4:0] FS_AND = FS_AND_C,
  parameter logic [4:0] FS_ORR = FS_ORR_C,
  parameter logic [4:0] FS_EOR = FS_EOR_C
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [4:0]      status,
  output logic [CW_W-1:0] control_word,
  output logic [63:0]     constant,
  output logic            illegal,
  output logic [1:0]      state
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        zero_q, zero_d;
  op_e         op;
  ctrl_word_t  cw;
  logic        ill;
  logic [63:0] imm;
  logic [4:0]  rd, rn, rm;

  assign op = decode_op(ir_q[31:21]);
  assign rd = ir_q[4:0];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];

  imm_extend_legv8 u_imm (
    .ir_i       (ir_q),
    .constant_o (imm)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    zero_d  = zero_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instruction;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (op == OP_LDUR) begin
          state_d = ST_MEM;
        end else if (op == OP_CBZ || op == OP_CBNZ) begin
          state_d = ST_BRANCH;
          zero_d  = status[0];
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs never see status[0]; the CB branch decision uses the captured zero_q.
  always_comb begin
    cw  = '0;
    ill = 1'b0;
    case (state_q)
      ST_EXECUTE: begin
        case (op)
          OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
            cw.sa     = rn;
            cw.sb     = rm;
            cw.da     = rd;
            cw.en_alu = 1'b1;
            cw.wr     = 1'b1;
            cw.ps     = PS_INC;
            cw.b_sel  = op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI};
            cw.sl     = (op == OP_ADDS) || (op == OP_SUBS);
            case (op)
              OP_SUB, OP_SUBS, OP_SUBI: cw.fs = FS_SUB;
              OP_AND, OP_ANDI:          cw.fs = FS_AND;
              OP_ORR, OP_ORRI:          cw.fs = FS_ORR;
              OP_EOR:                   cw.fs = FS_EOR;
              default:                  cw.fs = FS_ADD;
            endcase
          end
          OP_LDUR: begin
            cw.sa    = rn;
            cw.b_sel = 1'b1;
            cw.fs    = FS_ADD;
            cw.ps    = PS_HOLD;
          end
          OP_STUR: begin
            cw.sa    = rn;
            cw.b_sel = 1'b1;
            cw.fs    = FS_ADD;
            cw.sb    = rd;
            cw.wm    = 1'b1;
            cw.ps    = PS_INC;
          end
          OP_B: begin
            cw.pc_sel = 1'b1;
            cw.ps     = PS_BRANCH;
          end
          OP_BL: begin
            cw.pc_sel = 1'b1;
            cw.ps     = PS_BRANCH;
            cw.en_pc  = 1'b1;
            cw.wr     = 1'b1;
            cw.da     = 5'd30;
          end
          OP_BR: begin
            cw.sa = rn;
            cw.ps = PS_REG;
          end
          OP_CBZ, OP_CBNZ: begin
            cw.sa = 5'd31;
            cw.sb = rd;
            cw.fs = FS_ADD;
            cw.ps = PS_HOLD;
          end
          OP_BCOND: begin
            cw.pc_sel = 1'b1;
            cw.ps     = cond_taken(ir_q[3:0], status[4:1]) ? PS_BRANCH : PS_INC;
          end
          default: begin
            cw.ps = PS_INC;
            ill   = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        cw.sa     = rn;
        cw.b_sel  = 1'b1;
        cw.fs     = FS_ADD;
        cw.en_mem = 1'b1;
        cw.wr     = 1'b1;
        cw.da     = rd;
        cw.ps     = PS_INC;
      end
      ST_BRANCH: begin
        cw.pc_sel = 1'b1;
        if (op == OP_CBZ) cw.ps = zero_q ? PS_BRANCH : PS_INC;
        else              cw.ps = zero_q ? PS_INC : PS_BRANCH;
      end
      default: cw = '0;
    endcase
  end

  assign control_word = cw;
  assign constant     = (state_q == ST_FETCH) ? 64'd0 : imm;
  assign illegal      = ill;
  assign state        = state_q;

endmodule

// File: tb/tb_control_fsm_legv8.sv
// tb/tb_control_fsm_legv8.sv - scoreboard bench for control_fsm_legv8
module tb_control_fsm_legv8;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [29:0] control_word;
  logic [63:0] constant;
  logic        illegal;
  logic [1:0]  state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [4:0]  stat;
    logic [29:0] cw;
    logic [63:0] k;
    logic        chk_k;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  control_fsm_legv8 dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .illegal      (illegal),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [29:0] mk_cw(
    input logic en_pc, input logic en_mem, input logic en_alu, input logic pcsel,
    input logic bsel, input logic sl, input logic wm, input logic wr,
    input logic [1:0] ps, input logic [4:0] fs, input logic [4:0] sbr,
    input logic [4:0] sa, input logic [4:0] da);
    return {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sbr, sa, da};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [4:0] stat,
                      input logic [29:0] cw, input logic [63:0] k, input logic chk_k,
                      input logic ill);
    exp_t e;
    e.tag = tag; e.st = st; e.stat = stat; e.cw = cw; e.k = k; e.chk_k = chk_k; e.ill = ill;
    sb_q.push_back(e);
  endtask

  task automatic expect_now();
    exp_t e;
    e = sb_q.pop_front();
    status = e.stat;
    #1;
    check({e.tag, ".state"}, {62'd0, state}, {62'd0, e.st});
    check({e.tag, ".cw"}, {34'd0, control_word}, {34'd0, e.cw});
    check({e.tag, ".ill"}, {63'd0, illegal}, {63'd0, e.ill});
    if (e.chk_k) check({e.tag, ".const"}, constant, e.k);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      expect_now();
      @(posedge clock);
      #1;
    end
  endtask

  logic [29:0] z30;
  logic [29:0] br_t, br_n;

  initial begin
    z30  = 30'd0;
    br_t = mk_cw(0,0,0,1,0,0,0,0,2'b11,5'd0,5'd0,5'd0,5'd0);
    br_n = mk_cw(0,0,0,1,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0);
    reset = 1'b1;
    instruction = 32'h0;
    status = 5'd0;
    push("rst.async", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    expect_now();
    @(posedge clock); @(posedge clock); #1;
    push("rst.held", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    expect_now();
    @(negedge clock);
    reset = 1'b0;
    #1;

    instruction = 32'hAB020023;
    push("adds.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("adds.e", 2'd1, 5'd0, mk_cw(0,0,1,0,0,1,0,1,2'b01,5'b01000,5'd2,5'd1,5'd3), 64'd0, 1'b1, 1'b0);
    drain();

    instruction = 32'hF85F8045;
    push("ldur.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("ldur.e", 2'd1, 5'd0, mk_cw(0,0,0,0,1,0,0,0,2'b00,5'b01000,5'd0,5'd2,5'd0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
    push("ldur.m", 2'd2, 5'd0, mk_cw(0,1,0,0,1,0,0,1,2'b01,5'b01000,5'd0,5'd2,5'd5), 64'd0, 1'b0, 1'b0);
    drain();

    instruction = 32'hB4000064;
    push("cbz1.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("cbz1.e", 2'd1, 5'b00001, mk_cw(0,0,0,0,0,0,0,0,2'b00,5'b01000,5'd4,5'd31,5'd0), 64'd0, 1'b0, 1'b0);
    push("cbz1.b", 2'd3, 5'b00000, br_t, 64'd3, 1'b1, 1'b0);
    drain();

    push("cbz0.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("cbz0.e", 2'd1, 5'b00000, mk_cw(0,0,0,0,0,0,0,0,2'b00,5'b01000,5'd4,5'd31,5'd0), 64'd0, 1'b0, 1'b0);
    push("cbz0.b", 2'd3, 5'b00001, br_n, 64'd3, 1'b1, 1'b0);
    drain();

    instruction = 32'hB5000064;
    push("cbnz.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("cbnz.e", 2'd1, 5'b00000, mk_cw(0,0,0,0,0,0,0,0,2'b00,5'b01000,5'd4,5'd31,5'd0), 64'd0, 1'b0, 1'b0);
    push("cbnz.b", 2'd3, 5'b00001, br_t, 64'd3, 1'b1, 1'b0);
    drain();

    instruction = 32'h54FFFFCB;
    push("blt_t.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("blt_t.e", 2'd1, 5'b00100, br_t, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    push("blt_n.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("blt_n.e", 2'd1, 5'b10100, br_n, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    drain();

    instruction = 32'h54000080;
    push("beq.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("beq.e", 2'd1, 5'b00010, br_t, 64'd4, 1'b1, 1'b0);
    drain();
    instruction = 32'h5400008E;
    push("bal.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("bal.e", 2'd1, 5'b00000, br_t, 64'd4, 1'b1, 1'b0);
    drain();
    instruction = 32'h5400008F;
    push("bnv.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("bnv.e", 2'd1, 5'b11111, br_n, 64'd4, 1'b1, 1'b0);
    drain();

    instruction = 32'h913FFD07;
    push("addi.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("addi.e", 2'd1, 5'd0, mk_cw(0,0,1,0,1,0,0,1,2'b01,5'b01000,5'd31,5'd8,5'd7), 64'h0000_0000_0000_0FFF, 1'b1, 1'b0);
    drain();

    instruction = 32'hCB030041;
    push("sub.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("sub.e", 2'd1, 5'd0, mk_cw(0,0,1,0,0,0,0,1,2'b01,5'b01001,5'd3,5'd2,5'd1), 64'd0, 1'b1, 1'b0);
    drain();

    instruction = 32'hCA0B0149;
    push("eor.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("eor.e", 2'd1, 5'd0, mk_cw(0,0,1,0,0,0,0,1,2'b01,5'b01100,5'd11,5'd10,5'd9), 64'd0, 1'b1, 1'b0);
    drain();

    instruction = 32'hF8010026;
    push("stur.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("stur.e", 2'd1, 5'd0, mk_cw(0,0,0,0,1,0,1,0,2'b01,5'b01000,5'd6,5'd1,5'd0), 64'd16, 1'b1, 1'b0);
    drain();

    instruction = 32'h17FFFFFF;
    push("b.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("b.e", 2'd1, 5'd0, br_t, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    drain();

    instruction = 32'h94000005;
    push("bl.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("bl.e", 2'd1, 5'd0, mk_cw(1,0,0,1,0,0,0,1,2'b11,5'd0,5'd0,5'd0,5'd30), 64'd5, 1'b1, 1'b0);
    drain();

    instruction = 32'hD60003C0;
    push("br.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("br.e", 2'd1, 5'd0, mk_cw(0,0,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd30,5'd0), 64'd0, 1'b1, 1'b0);
    drain();

    instruction = 32'h00000000;
    push("ill.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("ill.e", 2'd1, 5'd0, br_n ^ mk_cw(0,0,0,1,0,0,0,0,2'b00,5'd0,5'd0,5'd0,5'd0), 64'd0, 1'b1, 1'b1);
    push("ill.after", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    expect_now(); @(posedge clock); #1;
    expect_now(); @(posedge clock); #1;
    expect_now();

    instruction = 32'hF85F8045;
    @(posedge clock); #1;
    push("rmem.e", 2'd1, 5'd0, mk_cw(0,0,0,0,1,0,0,0,2'b00,5'b01000,5'd0,5'd2,5'd0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
    expect_now(); @(posedge clock); #1;
    push("rmem.m", 2'd2, 5'd0, mk_cw(0,1,0,0,1,0,0,1,2'b01,5'b01000,5'd0,5'd2,5'd5), 64'd0, 1'b0, 1'b0);
    expect_now();
    reset = 1'b1;
    push("rmem.abort", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    expect_now();
    @(posedge clock); #1;
    push("rmem.next", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    expect_now();
    @(negedge clock);
    reset = 1'b0;
    #1;

    instruction = 32'hAB020023;
    push("post.f", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    push("post.e", 2'd1, 5'd0, mk_cw(0,0,1,0,0,1,0,1,2'b01,5'b01000,5'd2,5'd1,5'd3), 64'd0, 1'b1, 1'b0);
    push("post.done", 2'd0, 5'd0, z30, 64'd0, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
